// File: rtl/bit_serializer32.sv
// rtl/bit_serializer32.sv - 32-bit word to serial bit stream controller for a 32:1 bit mux
//
// Purpose:
//   Accepts a word and a bit count over a valid/ready handshake, holds the word
//   on word_o and steps sel_o through the bit indices of an external
//   combinational 32:1 mux. The mux output comes back on mux_bit_i and is
//   forwarded as a serial stream with its own valid/ready handshake. last_o
//   marks the final bit of each word.
//
// Configuration:
//   BIT_SERIALIZER_B2B_EN - when defined, a new word can be accepted in the
//   same cycle as the previous word's last beat, so words stream with no
//   bubble cycle between them.
//
// Ports:
//   clk_i       in   single clock
//   rst_i       in   synchronous active-high reset
//   word_i      in   word to serialize
//   len_i       in   number of bits to send minus 1
//   valid_i     in   word_i/len_i valid
//   ready_o     out  block can accept a word
//   flush_i     in   synchronous abort of the current word
//   word_o      out  held word, drives the mux data input
//   sel_o       out  current bit index, drives the mux select
//   mux_bit_i   in   mux output for (word_o, sel_o)
//   bit_o       out  serial bit (mux_bit_i passed through)
//   bit_valid_o out  bit_o valid
//   bit_ready_i in   consumer accepts bit_o
//   last_o      out  bit_o is the final bit of the word
//   busy_o      out  a word is being shifted out

module bit_serializer32 #(
  parameter int DATA_W    = 32,
  parameter int SEL_W     = 5,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [DATA_W-1:0] word_i,
  input  logic [SEL_W-1:0]  len_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic              flush_i,
  output logic [DATA_W-1:0] word_o,
  output logic [SEL_W-1:0]  sel_o,
  input  logic              mux_bit_i,
  output logic              bit_o,
  output logic              bit_valid_o,
  input  logic              bit_ready_i,
  output logic              last_o,
  output logic              busy_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [SEL_W-1:0]  cnt_q,   cnt_d;
  logic [SEL_W-1:0]  len_q,   len_d;
  logic [DATA_W-1:0] word_q,  word_d;
  logic [SEL_W-1:0]  sel_q,   sel_d;

  logic last;
  logic can_take;
  logic accept;
  logic beat;

  // cnt counts beats from 0 up to len_q; it never passes len_q, so a 5-bit
  // counter covers the full 32-bit word without wrapping.
  assign last = (state_q == SHIFT) && (cnt_q == len_q);

`ifdef BIT_SERIALIZER_B2B_EN
  // Taking a new word while the last bit is being consumed keeps the stream
  // gap-free; this makes ready_o combinational from bit_ready_i.
  assign can_take = (state_q == IDLE) || (last && bit_ready_i);
`else
  assign can_take = (state_q == IDLE);
`endif

  // Reset and flush both block acceptance, so a word offered alongside a
  // flush stays with the upstream until the following cycle.
  assign ready_o = can_take && !rst_i && !flush_i;
  assign accept  = valid_i && ready_o;
  assign beat    = (state_q == SHIFT) && bit_ready_i;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    word_d  = word_q;

    if (flush_i) begin
      // The held word is kept; only the position and state are cleared.
      state_d = IDLE;
      cnt_d   = '0;
    end else if (accept) begin
      // With back-to-back enabled this also covers the last-beat cycle, in
      // which the new word replaces the old one and the state stays SHIFT.
      state_d = SHIFT;
      cnt_d   = '0;
      len_d   = len_i;
      word_d  = word_i;
    end else if (beat) begin
      if (last) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + SEL_W'(1);
      end
    end
  end

  // The select is registered from the next count so the mux sees a stable
  // index for the whole cycle in which the bit is presented.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign sel_d = len_d - cnt_d;
    end else begin : g_lsb_first
      assign sel_d = cnt_d;
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      len_q   <= '0;
      word_q  <= '0;
      sel_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      len_q   <= len_d;
      word_q  <= word_d;
      sel_q   <= sel_d;
    end
  end

  assign word_o      = word_q;
  assign sel_o       = sel_q;
  assign bit_o       = mux_bit_i;
  assign bit_valid_o = (state_q == SHIFT);
  assign busy_o      = (state_q == SHIFT);
  assign last_o      = last;

endmodule

// File: tb/tb_bit_serializer32.sv
// tb/tb_bit_serializer32.sv - directed self-checking bench for bit_serializer32
module tb_bit_serializer32;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [31:0] word_i;
  logic [4:0]  len_i;
  logic        valid_i;
  logic        flush_i;
  logic        bit_ready_i;

  logic        ready_l, mux_l, bit_l, bv_l, last_l, busy_l;
  logic [31:0] word_l;
  logic [4:0]  sel_l;
  logic        ready_m, mux_m, bit_m, bv_m, last_m, busy_m;
  logic [31:0] word_m;
  logic [4:0]  sel_m;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // Behavioural 32:1 mux closing the loop for each instance.
  assign mux_l = word_l[sel_l];
  assign mux_m = word_m[sel_m];

  bit_serializer32 #(.MSB_FIRST(1'b0)) u_lsb (
    .clk_i(clk), .rst_i(rst_i), .word_i(word_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_l), .flush_i(flush_i),
    .word_o(word_l), .sel_o(sel_l), .mux_bit_i(mux_l), .bit_o(bit_l),
    .bit_valid_o(bv_l), .bit_ready_i(bit_ready_i), .last_o(last_l),
    .busy_o(busy_l)
  );

  bit_serializer32 #(.MSB_FIRST(1'b1)) u_msb (
    .clk_i(clk), .rst_i(rst_i), .word_i(word_i), .len_i(len_i),
    .valid_i(valid_i), .ready_o(ready_m), .flush_i(flush_i),
    .word_o(word_m), .sel_o(sel_m), .mux_bit_i(mux_m), .bit_o(bit_m),
    .bit_valid_o(bv_m), .bit_ready_i(bit_ready_i), .last_o(last_m),
    .busy_o(busy_m)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven here.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  logic [31:0] w;
  int          nb;
  int          cyc_of [8];
  logic        acc;
  logic [7:0]  b2b_bits;

  initial begin
    rst_i = 1'b1; word_i = '0; len_i = '0; valid_i = 1'b0;
    flush_i = 1'b0; bit_ready_i = 1'b1;

    // Reset
    next_cycle(); #1;
    chk("rst_ready", ready_l, 0);
    next_cycle(); #1;
    chk("rst_word", word_l, 0);
    chk("rst_sel", sel_l, 0);
    chk("rst_bv", bv_l, 0);
    chk("rst_busy", busy_l, 0);
    chk("rst_last", last_l, 0);
    rst_i = 1'b0; #1;
    chk("post_rst_ready", ready_l, 1);

    // LSB first, 8 bits of 0xA5A50F0F
    w = 32'hA5A5_0F0F;
    next_cycle(); valid_i = 1'b1; word_i = w; len_i = 5'd7; #1;
    chk("t1_ready", ready_l, 1);
    for (int i = 0; i < 8; i++) begin
      next_cycle(); valid_i = 1'b0; #1;
      chk("t1_bv", bv_l, 1);
      chk("t1_sel", sel_l, i);
      chk("t1_bit", bit_l, w[i]);
      chk("t1_last", last_l, (i == 7));
    end
    next_cycle(); #1;
    chk("t1_idle_bv", bv_l, 0);
    chk("t1_idle_ready", ready_l, 1);
    chk("t1_word_held", word_l, w);

    // MSB first, 32 bits of 0x80000001
    w = 32'h8000_0001;
    next_cycle(); valid_i = 1'b1; word_i = w; len_i = 5'd31; #1;
    chk("t2_ready", ready_m, 1);
    for (int i = 0; i < 32; i++) begin
      next_cycle(); valid_i = 1'b0; #1;
      chk("t2_bv", bv_m, 1);
      chk("t2_sel", sel_m, 31 - i);
      chk("t2_bit", bit_m, (i == 0 || i == 31));
      chk("t2_last", last_m, (i == 31));
    end
    next_cycle(); #1;
    chk("t2_idle_busy", busy_m, 0);
    chk("t2_idle_ready", ready_m, 1);

    // Single-bit word under backpressure
    next_cycle(); valid_i = 1'b1; word_i = 32'h1; len_i = 5'd0; #1;
    chk("t3_ready", ready_l, 1);
    for (int i = 0; i < 3; i++) begin
      next_cycle(); valid_i = 1'b0; bit_ready_i = (i == 2); #1;
      chk("t3_bv", bv_l, 1);
      chk("t3_sel", sel_l, 0);
      chk("t3_bit", bit_l, 1);
      chk("t3_last", last_l, 1);
    end
    next_cycle(); bit_ready_i = 1'b1; #1;
    chk("t3_idle_bv", bv_l, 0);
    chk("t3_idle_ready", ready_l, 1);

    // Stall mid-word at sel 3
    w = 32'h0000_00A8;
    next_cycle(); valid_i = 1'b1; word_i = w; len_i = 5'd7; #1;
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        for (int j = 0; j < 5; j++) begin
          next_cycle(); valid_i = 1'b0; bit_ready_i = 1'b0; #1;
          chk("t4_stall_bv", bv_l, 1);
          chk("t4_stall_sel", sel_l, 3);
          chk("t4_stall_bit", bit_l, 1);
          chk("t4_stall_word", word_l, w);
          chk("t4_stall_last", last_l, 0);
        end
      end
      next_cycle(); valid_i = 1'b0; bit_ready_i = 1'b1; #1;
      chk("t4_sel", sel_l, i);
      chk("t4_bit", bit_l, w[i]);
      chk("t4_last", last_l, (i == 7));
    end
    next_cycle(); #1;
    chk("t4_idle_bv", bv_l, 0);

    // Flush at sel 10 while a new word is offered, then reset mid-word
    w = 32'hFFFF_0000;
    next_cycle(); valid_i = 1'b1; word_i = w; len_i = 5'd20; #1;
    for (int i = 0; i < 10; i++) begin
      next_cycle(); valid_i = 1'b0; #1;
      chk("t5_sel", sel_l, i);
    end
    next_cycle(); flush_i = 1'b1; valid_i = 1'b1; word_i = 32'h1234_5678; len_i = 5'd3; #1;
    chk("t5_sel10", sel_l, 10);
    chk("t5_flush_ready", ready_l, 0);
    next_cycle(); flush_i = 1'b0; #1;
    chk("t5_flush_busy", busy_l, 0);
    chk("t5_flush_bv", bv_l, 0);
    chk("t5_flush_word", word_l, w);
    chk("t5_flush_ready2", ready_l, 1);
    next_cycle(); valid_i = 1'b0; #1;
    chk("t5_acc_busy", busy_l, 1);
    chk("t5_acc_word", word_l, 32'h1234_5678);
    chk("t5_acc_sel", sel_l, 0);
    chk("t5_acc_bit", bit_l, 0);
    next_cycle(); rst_i = 1'b1; #1;
    chk("t5_sel1", sel_l, 1);
    chk("t5_rst_ready", ready_l, 0);
    next_cycle(); rst_i = 1'b0; #1;
    chk("t5_rst_word", word_l, 0);
    chk("t5_rst_sel", sel_l, 0);
    chk("t5_rst_bv", bv_l, 0);
    chk("t5_rst_last", last_l, 0);

    // Two 4-bit words offered back to back: 0x5 then 0xA
    next_cycle(); valid_i = 1'b1; word_i = 32'h5; len_i = 5'd3; #1;
    chk("t6_ready_a", ready_l, 1);
    next_cycle(); word_i = 32'hA; #1;
    nb = 0;
    acc = 1'b0;
    b2b_bits = '0;
    for (int c = 0; c < 12; c++) begin
      if (bv_l && nb < 8) begin
        b2b_bits[nb] = bit_l;
        cyc_of[nb] = c;
        nb++;
      end
      if (valid_i && ready_l) acc = 1'b1;
      next_cycle();
      if (acc) valid_i = 1'b0;
      #1;
    end
    chk("t6_beats", nb, 8);
    chk("t6_bits", b2b_bits, 8'b1010_0101);
    chk("t6_b_accepted", acc, 1);
    for (int k = 0; k < 8; k++) begin
`ifdef BIT_SERIALIZER_B2B_EN
      chk("t6_beat_cycle", cyc_of[k], k);
`else
      chk("t6_beat_cycle", cyc_of[k], (k < 4) ? k : k + 1);
`endif
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
